// File: rtl/myfilter_cfgreg.sv
// myfilter_cfgreg: serial-to-parallel configuration register bank fed by the I2C slave.
// Frames {addr, data} arrive MSB first on sd_in while sde_in is high. dl_in commits
// the received frame and ul_in loads readback data for shifting out on sd_out.
// Optional feature: define MYFILTER_CFGREG_PARITY_EN to append an even parity bit to
// every frame. The bit is checked on download and generated on upload.
module myfilter_cfgreg #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_REGS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sde_in,
  input  logic                       sd_in,
  output logic                       sd_out,
  input  logic                       dl_in,
  input  logic                       ul_in,
  output logic [N_REGS*DATA_W-1:0]   cfg_out,
  output logic                       cfg_wr_out,
  output logic [ADDR_W-1:0]          cfg_addr_out,
  output logic                       err_out
);

`ifdef MYFILTER_CFGREG_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned FW    = ADDR_W + DATA_W + PAR_W;
  localparam int unsigned CNT_W = $clog2(FW + 1);
  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(N_REGS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic [FW-1:0]     sreg_q, sreg_d;

  logic [DATA_W-1:0] regs [N_REGS];
  logic [ADDR_W-1:0] cfg_addr_q;
  logic              cfg_wr_q;
  logic              err_q;

  logic              wr_en;
  logic              err_set;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              addr_ok;
  logic              par_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] rb_data;
  logic [FW-1:0]     rb_frame;

  // Field extraction from the received frame and readback frame assembly
  assign frame_addr = sreg_q[FW-1 -: ADDR_W];
  assign frame_data = sreg_q[PAR_W +: DATA_W];
  assign addr_ok    = {1'b0, frame_addr} < ADDR_LIM;
  assign wr_idx     = IDX_W'(frame_addr);
  // cfg_addr_q only ever holds an address that passed the range check
  assign rb_data    = regs[IDX_W'(cfg_addr_q)];
`ifdef MYFILTER_CFGREG_PARITY_EN
  assign par_ok     = ~(^sreg_q);
  assign rb_frame   = {cfg_addr_q, rb_data, ^{cfg_addr_q, rb_data}};
`else
  assign par_ok     = 1'b1;
  assign rb_frame   = {cfg_addr_q, rb_data};
`endif

  // Next-state logic: strobes take priority over shifting, and dl_in over ul_in
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    sreg_d  = sreg_q;
    wr_en   = 1'b0;
    err_set = 1'b0;
    if (dl_in) begin
      if ((state_q == ST_FULL) && !ovr_q && addr_ok && par_ok) begin
        wr_en = 1'b1;
      end else begin
        err_set = 1'b1;
      end
      if (ul_in) begin
        err_set = 1'b1;
      end
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (ul_in) begin
      sreg_d  = rb_frame;
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (sde_in) begin
      sreg_d = {sreg_q[FW-2:0], sd_in};
      case (state_q)
        ST_IDLE: begin
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FW - 1)) begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          ovr_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Shift FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      sreg_q  <= sreg_d;
    end
  end

  // Register bank, write pulse, last address and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_REGS; k++) begin
        regs[k] <= '0;
      end
      cfg_addr_q <= '0;
      cfg_wr_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cfg_wr_q <= wr_en;
      if (wr_en) begin
        regs[wr_idx] <= frame_data;
        cfg_addr_q   <= frame_addr;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Flatten the bank onto the output bus
  for (genvar k = 0; k < N_REGS; k++) begin : g_cfg
    assign cfg_out[k*DATA_W +: DATA_W] = regs[k];
  end

  assign sd_out       = sreg_q[FW-1];
  assign cfg_wr_out   = cfg_wr_q;
  assign cfg_addr_out = cfg_addr_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_myfilter_cfgreg.sv
// tb_myfilter_cfgreg: scoreboard bench for myfilter_cfgreg.
// The reference model treats the shift path as a FIFO of frame bits and counts the
// shifts since the last strobe. A frame is accepted when exactly one frame width of
// bits has arrived since the last strobe.
module tb_myfilter_cfgreg;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_REGS = 8;
`ifdef MYFILTER_CFGREG_PARITY_EN
  localparam int unsigned FW = ADDR_W + DATA_W + 1;
`else
  localparam int unsigned FW = ADDR_W + DATA_W;
`endif
  localparam int unsigned CW = N_REGS * DATA_W;

  logic              clk = 1'b0;
  logic              rst, sde, sd, dl, ul;
  logic              sd_o;
  logic [CW-1:0]     cfg;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic              err;

  myfilter_cfgreg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REGS(N_REGS)) dut (
    .clk(clk), .rst(rst), .sde_in(sde), .sd_in(sd), .sd_out(sd_o),
    .dl_in(dl), .ul_in(ul), .cfg_out(cfg), .cfg_wr_out(wr),
    .cfg_addr_out(addr), .err_out(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              sd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic [CW-1:0]     cfg;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  bit                m_bits[$];
  int                m_nshift;
  logic [DATA_W-1:0] m_bank [N_REGS];
  logic [ADDR_W-1:0] m_addr;
  logic              m_err;
  logic              m_wr;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] make_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
`ifdef MYFILTER_CFGREG_PARITY_EN
    return {a, d, ^{a, d}};
`else
    return {a, d};
`endif
  endfunction

  function automatic logic [CW-1:0] model_cfg();
    logic [CW-1:0] c;
    for (int k = 0; k < int'(N_REGS); k++) c[k*DATA_W +: DATA_W] = m_bank[k];
    return c;
  endfunction

  // Advance the model by one clock with the given inputs, then queue the expected outputs
  task automatic model_step(input logic r, input logic s_e, input logic s_d, input logic d_l, input logic u_l);
    logic [FW-1:0]     f;
    logic [ADDR_W-1:0] fa;
    bit                ok;
    exp_t              e;
    if (r) begin
      m_bits.delete();
      for (int i = 0; i < int'(FW); i++) m_bits.push_back(1'b0);
      m_nshift = 0;
      for (int k = 0; k < int'(N_REGS); k++) m_bank[k] = '0;
      m_addr = '0;
      m_err  = 1'b0;
      m_wr   = 1'b0;
    end else begin
      m_wr = 1'b0;
      if (d_l) begin
        for (int i = 0; i < int'(FW); i++) f[int'(FW) - 1 - i] = m_bits[i];
        fa = f[FW-1 -: ADDR_W];
        ok = (m_nshift == int'(FW)) && (int'(fa) < int'(N_REGS));
`ifdef MYFILTER_CFGREG_PARITY_EN
        ok = ok && !(^f);
`endif
        if (ok) begin
          m_bank[int'(fa)] = f[FW-1-ADDR_W -: DATA_W];
          m_addr = fa;
          m_wr   = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        if (u_l) m_err = 1'b1;
        m_nshift = 0;
      end else if (u_l) begin
        f = make_frame(m_addr, m_bank[int'(m_addr)]);
        m_bits.delete();
        for (int i = int'(FW) - 1; i >= 0; i--) m_bits.push_back(f[i]);
        m_nshift = 0;
      end else if (s_e) begin
        void'(m_bits.pop_front());
        m_bits.push_back(s_d);
        m_nshift++;
      end
    end
    e.sd   = m_bits[0];
    e.wr   = m_wr;
    e.addr = m_addr;
    e.err  = m_err;
    e.cfg  = model_cfg();
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus, applied on the falling edge
  task automatic drive(input logic r, input logic s_e, input logic s_d, input logic d_l, input logic u_l);
    @(negedge clk);
    rst = r; sde = s_e; sd = s_d; dl = d_l; ul = u_l;
    model_step(r, s_e, s_d, d_l, u_l);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic shift_bits(input logic [FW+3:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, v[i], 1'b0, 1'b0);
  endtask

  task automatic shift_gappy(input logic [FW+3:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
      drive(1'b0, 1'b1, v[i], 1'b0, 1'b0);
    end
  endtask

  // Monitor: compare the DUT against the next expected snapshot after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sd_out", CW'(sd_o), CW'(e.sd));
        chk("cfg_wr_out", CW'(wr), CW'(e.wr));
        chk("cfg_addr_out", CW'(addr), CW'(e.addr));
        chk("err_out", CW'(err), CW'(e.err));
        chk("cfg_out", cfg, e.cfg);
      end
    end
  end

  initial begin
    logic [FW-1:0]   rb;
    logic [FW+3:0]   v;
    logic [CW-1:0]   snap;
    int              kind, len;
    rst = 1'b1; sde = 1'b0; sd = 1'b0; dl = 1'b0; ul = 1'b0;

    // Reset state
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    settle();
    chk("rst_sd", CW'(sd_o), '0);
    chk("rst_cfg", cfg, '0);
    chk("rst_wr", CW'(wr), '0);
    chk("rst_addr", CW'(addr), '0);
    chk("rst_err", CW'(err), '0);

    // Write 0x2BEEF
    v = (FW+4)'(make_frame(4'h2, 16'hBEEF));
    shift_bits(v, int'(FW));
    drive(0, 0, 0, 1, 0);
    settle();
    chk("wr_data", CW'(cfg[47:32]), CW'(16'hBEEF));
    chk("wr_addr", CW'(addr), CW'(2));
    chk("wr_pulse", CW'(wr), CW'(1));
    chk("wr_err", CW'(err), '0);
    drive(0, 0, 0, 0, 0);
    settle();
    chk("wr_pulse_end", CW'(wr), '0);

    // Readback of the frame just written
    drive(0, 0, 0, 0, 1);
    settle();
    rb[FW-1] = sd_o;
    for (int i = int'(FW) - 2; i >= 0; i--) begin
      drive(0, 1, 0, 0, 0);
      settle();
      rb[i] = sd_o;
    end
    chk("rb_frame", CW'(rb), CW'(make_frame(4'h2, 16'hBEEF)));
    drive(0, 1, 0, 0, 0);
    settle();
    chk("rb_drained", CW'(sd_o), '0);

    // Short frame, then a valid frame
    shift_bits(v, int'(FW) - 1);
    drive(0, 0, 0, 1, 0);
    settle();
    chk("short_wr", CW'(wr), '0);
    chk("short_err", CW'(err), CW'(1));
    v = (FW+4)'(make_frame(4'h5, 16'h1234));
    shift_bits(v, int'(FW));
    drive(0, 0, 0, 1, 0);
    settle();
    chk("after_short_data", CW'(cfg[95:80]), CW'(16'h1234));
    chk("after_short_wr", CW'(wr), CW'(1));

    // Invalid address leaves the bank alone
    drive(1, 0, 0, 0, 0);
    v = (FW+4)'(make_frame(4'h2, 16'hBEEF));
    shift_bits(v, int'(FW));
    drive(0, 0, 0, 1, 0);
    settle();
    snap = cfg;
    chk("pre_badaddr_err", CW'(err), '0);
    v = (FW+4)'(make_frame(4'hA, 16'h1234));
    shift_bits(v, int'(FW));
    drive(0, 0, 0, 1, 0);
    settle();
    chk("badaddr_cfg", cfg, snap);
    chk("badaddr_wr", CW'(wr), '0);
    chk("badaddr_err", CW'(err), CW'(1));

    // Overrun
    drive(1, 0, 0, 0, 0);
    v = (FW+4)'(make_frame(4'h3, 16'h5A5A));
    shift_bits(v, int'(FW) + 1);
    drive(0, 0, 0, 1, 0);
    settle();
    chk("ovr_wr", CW'(wr), '0);
    chk("ovr_err", CW'(err), CW'(1));

    // Collision of dl_in and ul_in on a complete frame: write happens, error set
    drive(1, 0, 0, 0, 0);
    v = (FW+4)'(make_frame(4'h1, 16'hC0DE));
    shift_bits(v, int'(FW));
    drive(0, 1, 0, 1, 1);
    settle();
    chk("coll_wr", CW'(wr), CW'(1));
    chk("coll_err", CW'(err), CW'(1));

    // Reset mid-frame
    shift_bits(v, 10);
    drive(1, 1, 1, 0, 0);
    settle();
    chk("midrst_sd", CW'(sd_o), '0);
    chk("midrst_cfg", cfg, '0);
    chk("midrst_wr", CW'(wr), '0);
    chk("midrst_addr", CW'(addr), '0);
    chk("midrst_err", CW'(err), '0);

`ifdef MYFILTER_CFGREG_PARITY_EN
    // Parity: wrong bit rejected, correct bit accepted
    drive(1, 0, 0, 0, 0);
    v = (FW+4)'(make_frame(4'h2, 16'hBEEF) ^ FW'(1));
    shift_bits(v, int'(FW));
    drive(0, 0, 0, 1, 0);
    settle();
    chk("par_bad_wr", CW'(wr), '0);
    chk("par_bad_err", CW'(err), CW'(1));
    v = (FW+4)'(make_frame(4'h2, 16'hBEEF));
    shift_bits(v, int'(FW));
    drive(0, 0, 0, 1, 0);
    settle();
    chk("par_good_wr", CW'(wr), CW'(1));
    chk("par_good_data", CW'(cfg[47:32]), CW'(16'hBEEF));
`endif

    // Randomized traffic
    drive(1, 0, 0, 0, 0);
    repeat (400) begin
      kind = $urandom_range(0, 11);
      if (kind <= 5) begin
        v = {4'($urandom), FW'($urandom)};
        if ($urandom_range(0, 1) == 0)
          v[FW-1:0] = make_frame(4'($urandom_range(0, 9)), 16'($urandom));
        case ($urandom_range(0, 5))
          0:       len = int'(FW) - 1;
          1:       len = int'(FW) + 1;
          default: len = int'(FW);
        endcase
        shift_gappy(v, len);
        drive(0, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1, 1'($urandom_range(0, 15) == 0));
      end else if (kind <= 8) begin
        drive(0, 1'($urandom), 1'($urandom), 0, 1);
        shift_gappy((FW+4)'({$urandom, $urandom}), int'(FW));
      end else if (kind == 9) begin
        shift_gappy((FW+4)'($urandom), $urandom_range(0, 12));
        drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        repeat ($urandom_range(1, 4)) drive(0, 1'($urandom), 1'($urandom), 0, 0);
      end
    end

    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", CW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
